// File: rtl/int_ctrl.sv
// Interrupt sequencer: accepts masked IRQs, saves EPC, redirects fetch to a
// per-source vector and restores the IF/ID contents on ERET.
// Optional build macro INT_LATCH_EN selects edge-latched request capture.
module int_ctrl #(
  parameter int          NUM_IRQ      = 4,
  parameter logic [31:0] HANDLER_BASE = 32'h0000_0800,
  parameter logic [31:0] VEC_STRIDE   = 32'h0000_0020
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_IRQ-1:0] irq,
  input  logic               mask_we,
  input  logic [NUM_IRQ-1:0] mask_wdata,
  input  logic               id_is_eret,
  input  logic               stall,
  input  logic [31:0]        if_pc,
  output logic               int_detected,
  output logic               int_restore,
  output logic               pc_redirect,
  output logic [31:0]        redirect_pc,
  output logic [31:0]        epc,
  output logic [2:0]         cause,
  output logic               in_handler,
  output logic [NUM_IRQ-1:0] mask
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_ENTER   = 2'd1;
  localparam logic [1:0] S_HANDLER = 2'd2;
  localparam logic [1:0] S_EXIT    = 2'd3;

  logic [1:0]         state;
  logic [1:0]         state_next;
  logic [NUM_IRQ-1:0] pending;
  logic [2:0]         pick;
  logic               accept;
  logic               leave;

`ifdef INT_LATCH_EN
  logic [NUM_IRQ-1:0] irq_q;
  logic [NUM_IRQ-1:0] latched;
  logic [NUM_IRQ-1:0] accept_clr;

  assign pending    = latched & mask;
  assign accept_clr = accept ? (NUM_IRQ'(1) << pick) : '0;

  // A rising edge re-latches a source even while its handler runs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irq_q   <= '0;
      latched <= '0;
    end else begin
      irq_q   <= irq;
      latched <= (latched | (irq & ~irq_q)) & ~accept_clr;
    end
  end
`else
  assign pending = irq & mask;
`endif

  // Fixed priority: scanning downward leaves the lowest set index in pick.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    pick = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (pending[i]) pick = 3'(i);
    end
  end

  assign accept = (state == S_IDLE) && (|pending) && !stall;
  assign leave  = (state == S_HANDLER) && id_is_eret && !stall;

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:    if (accept) state_next = S_ENTER;
      S_ENTER:   state_next = S_HANDLER;
      S_HANDLER: if (leave) state_next = S_EXIT;
      S_EXIT:    state_next = S_IDLE;
      default:   state_next = S_IDLE;
    endcase
  end

  // Outputs are registered from state_next so each is high exactly while the
  // FSM sits in the matching state.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= S_IDLE;
      mask         <= '0;
      epc          <= '0;
      cause        <= '0;
      int_detected <= 1'b0;
      int_restore  <= 1'b0;
      pc_redirect  <= 1'b0;
      in_handler   <= 1'b0;
      redirect_pc  <= '0;
    end else begin
      state        <= state_next;
      int_detected <= (state_next == S_ENTER);
      int_restore  <= (state_next == S_EXIT);
      pc_redirect  <= (state_next == S_ENTER) || (state_next == S_EXIT);
      in_handler   <= (state_next == S_HANDLER);

      if (accept) begin
        epc   <= if_pc;
        cause <= pick;
      end

      case (state_next)
        S_ENTER: redirect_pc <= HANDLER_BASE + VEC_STRIDE * 32'(pick);
        S_EXIT:  redirect_pc <= epc;
        default: redirect_pc <= '0;
      endcase

      if (mask_we) mask <= mask_wdata;
    end
  end

endmodule
